instruction_fetch_unit: RTL

//   Front-end stage that sits directly upstream of the instruction decoder.
//   - Owns the fetch PC and issues in-order word requests to instruction memory.
//   - Buffers returned words in a small FIFO; presents {instruction, pc} to the

---
 rtl/instruction_fetch_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front-end stage feeding the instruction decoder. It owns the fetch PC,
// issues in-order word requests to instruction memory, buffers the returned
// words in a small FIFO and hands {instruction, pc} to decode over a
// valid/ready handshake. A redirect flushes the buffer, restarts fetch at the
// new PC and silently discards every response that was already in flight.
//
// Parameters
//   RESET_PC    fetch address after reset (word-aligned)
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), async active-low reset
//   o_imem_req_valid/addr     fetch request to memory
//   i_imem_req_ready          memory accepts the request
//   i_imem_rsp_valid/data/err in-order response from memory
//   i_redirect/_pc            one-cycle restart pulse and target PC
//   o_valid, i_ready          decode-side handshake
//   o_instruction, o_pc       buffered instruction and its PC (NOP when idle)
//   o_fetch_fault             entry is a bus error or misaligned-PC fault
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_imem_rsp_err,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_fetch_fault
);

  localparam int          PTR_W   = $clog2(FIFO_DEPTH);
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              req_valid_q, req_valid_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [PTR_W-1:0]  tag_wr_q, tag_wr_d;
  logic [PTR_W-1:0]  tag_rd_q, tag_rd_d;
  logic [PTR_W-1:0]  fifo_wr_q, fifo_wr_d;
  logic [PTR_W-1:0]  fifo_rd_q, fifo_rd_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  // PC tags of issued requests, consumed in order as responses return.
  logic [31:0]       tag_mem [FIFO_DEPTH];
  // Instruction buffer storage.
  logic [31:0]       fifo_data_mem  [FIFO_DEPTH];
  logic [31:0]       fifo_pc_mem    [FIFO_DEPTH];
  logic              fifo_fault_mem [FIFO_DEPTH];

  logic              fifo_we;
  logic [PTR_W-1:0]  fifo_widx;
  logic [31:0]       fifo_wdata;
  logic [31:0]       fifo_wpc;
  logic              fifo_wfault;
  logic [CNT_W:0]    credit_sum;

  logic fire;
  logic rsp_push;
  logic pop;
  logic misaligned;

  // A redirect withdraws a pending request in the same cycle it arrives.
  assign o_imem_req_valid = req_valid_q & ~i_redirect;
  assign o_imem_addr      = pc_q;
  assign fire             = o_imem_req_valid & i_imem_req_ready;

  // Responses are kept only when nothing stale is still ahead of them and
  // no flush is happening this cycle.
  assign rsp_push   = i_imem_rsp_valid & (drop_q == '0) & ~i_redirect;
  assign pop        = o_valid & i_ready & ~i_redirect;
  assign misaligned = i_redirect & (i_redirect_pc[1:0] != 2'b00);

  assign o_valid       = (fifo_cnt_q != '0);
  assign o_instruction = o_valid ? fifo_data_mem[fifo_rd_q] : NOP;
  assign o_pc          = o_valid ? fifo_pc_mem[fifo_rd_q] : pc_q;
  assign o_fetch_fault = o_valid & fifo_fault_mem[fifo_rd_q];

  // Next-state logic. The request valid is registered from the post-update
  // state, so it equals the credit rule evaluated on the current cycle's
  // counters while staying low throughout reset.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CNT_W'(fire) - CNT_W'(i_imem_rsp_valid);
    drop_d        = drop_q;
    tag_wr_d      = tag_wr_q + PTR_W'(fire);
    tag_rd_d      = tag_rd_q + PTR_W'(i_imem_rsp_valid);
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_cnt_d    = fifo_cnt_q + CNT_W'(rsp_push) - CNT_W'(pop);
    fifo_we       = 1'b0;
    fifo_widx     = fifo_wr_q;
    fifo_wdata    = i_imem_rsp_data;
    fifo_wpc      = tag_mem[tag_rd_q];
    fifo_wfault   = i_imem_rsp_err;

    if (fire) begin
      pc_d = pc_q + 32'd4;
    end

    if (i_imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end

    if (rsp_push) begin
      fifo_we   = 1'b1;
      fifo_wr_d = fifo_wr_q + PTR_W'(1);
      if (i_imem_rsp_err) begin
        state_d = ST_FAULT;
      end
    end

    if (pop) begin
      fifo_rd_d = fifo_rd_q + PTR_W'(1);
    end

    // Everything still in flight becomes stale, including responses that
    // were already being dropped from an earlier redirect.
    if (i_redirect) begin
      pc_d       = {i_redirect_pc[31:2], 2'b00};
      drop_d     = outstanding_q - CNT_W'(i_imem_rsp_valid);
      fifo_wr_d  = '0;
      fifo_rd_d  = '0;
      fifo_cnt_d = '0;
      fifo_we    = 1'b0;
      state_d    = ST_RUN;
      if (misaligned) begin
        state_d     = ST_FAULT;
        fifo_we     = 1'b1;
        fifo_widx   = '0;
        fifo_wdata  = NOP;
        fifo_wpc    = i_redirect_pc;
        fifo_wfault = 1'b1;
        fifo_wr_d   = PTR_W'(1);
        fifo_cnt_d  = CNT_W'(1);
      end
    end

    // Stale responses still hold credits until they return.
    credit_sum  = {1'b0, outstanding_d} + {1'b0, fifo_cnt_d};
    req_valid_d = (state_d == ST_RUN) && (credit_sum < DEPTH_W);
  end

  // Control state, including the RUN/FAULT machine.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      outstanding_q <= '0;
      drop_q        <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  // Storage arrays need no reset; occupancy is tracked by the counters.
  always_ff @(posedge i_clk) begin
    if (fire) begin
      tag_mem[tag_wr_q] <= pc_q;
    end
    if (fifo_we) begin
      fifo_data_mem[fifo_widx]  <= fifo_wdata;
      fifo_pc_mem[fifo_widx]    <= fifo_wpc;
      fifo_fault_mem[fifo_widx] <= fifo_wfault;
    end
  end

endmodule
